// File: rtl/osc_meas_pkg.sv
// osc_meas_pkg: shared types and defaults for the oscilloscope measurement blocks
package osc_meas_pkg;
    typedef enum logic [1:0] {SEEK, RISE, FALL} state_e;
    localparam int DEF_DW        = 12;
    localparam int DEF_HYST      = 8;
    localparam int DEF_NAVG_LOG2 = 2;
    localparam int DEF_TIMEOUT   = 4096;
    function automatic int pw_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction
endpackage

// File: rtl/amp_meas_hyst_if.sv
// amp_meas_hyst_if: ADC sample stream in, averaged amplitude/mean/period results out
interface amp_meas_hyst_if import osc_meas_pkg::*; #(
    parameter int DW = DEF_DW,
    parameter int PW = pw_width(DEF_TIMEOUT)
);
    logic          sample_valid;
    logic [DW-1:0] sample;
    logic          clear;
    logic [DW-1:0] vmax;
    logic [DW-1:0] vmin;
    logic [DW-1:0] amp;
    logic [DW-1:0] mean;
    logic [PW-1:0] period;
    logic          meas_valid;
    logic          dc_mode;
    modport master (
        output sample_valid, sample, clear,
        input  vmax, vmin, amp, mean, period, meas_valid, dc_mode
    );
    modport slave (
        input  sample_valid, sample, clear,
        output vmax, vmin, amp, mean, period, meas_valid, dc_mode
    );
endinterface

// File: rtl/meas_accum.sv
// meas_accum: sums per-period extremes/lengths and publishes the averages one cycle later
module meas_accum import osc_meas_pkg::*; #(
    parameter int DW        = DEF_DW,
    parameter int PW        = pw_width(DEF_TIMEOUT),
    parameter int NAVG_LOG2 = DEF_NAVG_LOG2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          acc_i,
    input  logic [DW-1:0] pmax_i,
    input  logic [DW-1:0] pmin_i,
    input  logic [PW-1:0] pcnt_i,
    input  logic          dc_i,
    input  logic [DW-1:0] dc_sample_i,
    input  logic          clr_i,
    output logic [DW-1:0] vmax_o,
    output logic [DW-1:0] vmin_o,
    output logic [DW-1:0] amp_o,
    output logic [DW-1:0] mean_o,
    output logic [PW-1:0] period_o,
    output logic          meas_valid_o,
    output logic          dc_mode_o
);
    localparam int NAV = 1 << NAVG_LOG2;
    localparam int SW  = DW + NAVG_LOG2;
    localparam int QW  = PW + NAVG_LOG2;
    logic [SW-1:0]        smax_q, smin_q, smax_d, smin_d;
    logic [QW-1:0]        sper_q, sper_d;
    logic [NAVG_LOG2:0]   ncnt_q;
    logic [DW-1:0]        avmax_q, avmin_q;
    logic [PW-1:0]        aper_q;
    logic                 pend_q, adc_q, last;
    always_comb begin
        smax_d = smax_q + SW'(pmax_i);
        smin_d = smin_q + SW'(pmin_i);
        sper_d = sper_q + QW'(pcnt_i);
        last   = acc_i && ncnt_q == (NAVG_LOG2 + 1)'(NAV - 1);
    end
    // averages are latched with the final accumulation, then amp/mean derived on the next edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smax_q       <= '0;
            smin_q       <= '0;
            sper_q       <= '0;
            ncnt_q       <= '0;
            avmax_q      <= '0;
            avmin_q      <= '0;
            aper_q       <= '0;
            adc_q        <= 1'b0;
            pend_q       <= 1'b0;
            vmax_o       <= '0;
            vmin_o       <= '0;
            amp_o        <= '0;
            mean_o       <= '0;
            period_o     <= '0;
            meas_valid_o <= 1'b0;
            dc_mode_o    <= 1'b0;
        end else begin
            pend_q       <= last || dc_i;
            meas_valid_o <= pend_q;
            if (pend_q) begin
                vmax_o    <= avmax_q;
                vmin_o    <= avmin_q;
                amp_o     <= DW'(({1'b0, avmax_q} - {1'b0, avmin_q}) >> 1);
                mean_o    <= DW'(({1'b0, avmax_q} + {1'b0, avmin_q}) >> 1);
                period_o  <= aper_q;
                dc_mode_o <= adc_q;
            end
            if (dc_i) begin
                avmax_q <= dc_sample_i;
                avmin_q <= dc_sample_i;
                aper_q  <= '0;
                adc_q   <= 1'b1;
            end else if (last) begin
                avmax_q <= DW'(smax_d >> NAVG_LOG2);
                avmin_q <= DW'(smin_d >> NAVG_LOG2);
                aper_q  <= PW'(sper_d >> NAVG_LOG2);
                adc_q   <= 1'b0;
            end
            if (clr_i || dc_i || last) begin
                smax_q <= '0;
                smin_q <= '0;
                sper_q <= '0;
                ncnt_q <= '0;
            end else if (acc_i) begin
                smax_q <= smax_d;
                smin_q <= smin_d;
                sper_q <= sper_d;
                ncnt_q <= ncnt_q + (NAVG_LOG2 + 1)'(1);
            end
        end
    end
endmodule

// File: rtl/amp_meas_hyst.sv
// amp_meas_hyst: hysteresis slope tracker that finds period boundaries, with timeout DC fallback
module amp_meas_hyst import osc_meas_pkg::*; #(
    parameter int DW        = DEF_DW,
    parameter int HYST      = DEF_HYST,
    parameter int NAVG_LOG2 = DEF_NAVG_LOG2,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst_n,
    amp_meas_hyst_if.slave bus
);
    localparam int PW = pw_width(TIMEOUT);
    localparam logic [DW:0] H = (DW + 1)'(HYST);
    state_e        st_q;
    logic [DW-1:0] rmin_q, rmax_q, peak_q, trough_q, pmax_q;
    logic          seeded_q, armed_q;
    logic [PW-1:0] pcnt_q;
    logic [DW:0]   s;
    logic          go, up, dn, bnd, tmo, acc;
    // threshold sums kept in DW+1 bits; the falling test adds HYST to the sample so it never underflows
    always_comb begin
        s   = {1'b0, bus.sample};
        up  = st_q == SEEK ? seeded_q && s >= {1'b0, rmin_q} + H : st_q == FALL && s >= {1'b0, trough_q} + H;
        dn  = st_q == SEEK ? seeded_q && s + H <= {1'b0, rmax_q} : st_q == RISE && s + H <= {1'b0, peak_q};
        go  = bus.sample_valid && !bus.clear;
        bnd = go && st_q == FALL && up;
        tmo = go && !bnd && pcnt_q == PW'(TIMEOUT - 1);
        acc = bnd && armed_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q     <= SEEK;
            rmin_q   <= '0;
            rmax_q   <= '0;
            peak_q   <= '0;
            trough_q <= '0;
            pmax_q   <= '0;
            seeded_q <= 1'b0;
            armed_q  <= 1'b0;
            pcnt_q   <= '0;
        end else if (bus.clear) begin
            st_q     <= SEEK;
            seeded_q <= 1'b0;
            armed_q  <= 1'b0;
            pcnt_q   <= '0;
        end else if (bus.sample_valid) begin
            // the timeout sample reseeds SEEK and closes the stalled window, so the next window starts empty
            pcnt_q <= bnd ? PW'(1) : tmo ? '0 : pcnt_q == PW'(TIMEOUT) ? pcnt_q : pcnt_q + PW'(1);
            if (tmo) begin
                st_q     <= SEEK;
                rmin_q   <= bus.sample;
                rmax_q   <= bus.sample;
                seeded_q <= 1'b1;
                armed_q  <= 1'b0;
            end else begin
                case (st_q)
                    SEEK: begin
                        rmin_q   <= !seeded_q || bus.sample < rmin_q ? bus.sample : rmin_q;
                        rmax_q   <= !seeded_q || bus.sample > rmax_q ? bus.sample : rmax_q;
                        seeded_q <= 1'b1;
                        if (up) begin
                            st_q   <= RISE;
                            peak_q <= bus.sample;
                        end else if (dn) begin
                            st_q     <= FALL;
                            trough_q <= bus.sample;
                        end
                    end
                    RISE: begin
                        if (dn) begin
                            st_q     <= FALL;
                            trough_q <= bus.sample;
                            pmax_q   <= peak_q;
                        end else if (bus.sample > peak_q) begin
                            peak_q <= bus.sample;
                        end
                    end
                    FALL: begin
                        if (up) begin
                            st_q    <= RISE;
                            peak_q  <= bus.sample;
                            armed_q <= 1'b1;
                        end else if (bus.sample < trough_q) begin
                            trough_q <= bus.sample;
                        end
                    end
                    default: st_q <= SEEK;
                endcase
            end
        end
    end
    meas_accum #(.DW(DW), .PW(PW), .NAVG_LOG2(NAVG_LOG2)) u_accum (
        .clk          (clk),
        .rst_n        (rst_n),
        .acc_i        (acc),
        .pmax_i       (pmax_q),
        .pmin_i       (trough_q),
        .pcnt_i       (pcnt_q),
        .dc_i         (tmo),
        .dc_sample_i  (bus.sample),
        .clr_i        (bus.clear),
        .vmax_o       (bus.vmax),
        .vmin_o       (bus.vmin),
        .amp_o        (bus.amp),
        .mean_o       (bus.mean),
        .period_o     (bus.period),
        .meas_valid_o (bus.meas_valid),
        .dc_mode_o    (bus.dc_mode)
    );
endmodule
